// File: rtl/flash_reader.sv
// flash_reader: SPI mode-0 flash read engine streaming little-endian 32-bit words.
// Define FLASH_READER_FAST_READ_EN for fast read (0x0B plus 8 dummy clocks).
module flash_reader #(
  parameter int WordCountBitWidth = 16,
  parameter int AddressBitWidth   = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [AddressBitWidth-1:0]   address,
  input  logic [WordCountBitWidth-1:0] word_count,
  output logic                         busy,
  output logic                         done,
  output logic [31:0]                  data_out,
  output logic                         data_valid,
  input  logic                         data_ready,
  output logic                         flash_clk,
  output logic                         flash_mosi,
  input  logic                         flash_miso,
  output logic                         flash_cs
);

  localparam int TxW    = 8 + AddressBitWidth;
  localparam int CntMax = (AddressBitWidth > 32) ? AddressBitWidth : 32;
  localparam int CntW   = $clog2(CntMax) + 1;

`ifdef FLASH_READER_FAST_READ_EN
  localparam logic [7:0] Cmd = 8'h0B;
`else
  localparam logic [7:0] Cmd = 8'h03;
`endif

  typedef enum logic [2:0] {
    Idle,
    SendCommand,
    SendAddress,
    Dummy,
    ReadData,
    Finish
  } state_e;

  state_e                       state_q;
  logic                         phase_q;
  logic                         stall_q;
  logic [CntW-1:0]              bit_cnt_q;
  logic [TxW-1:0]               tx_q;
  logic [31:0]                  rx_q;
  logic [WordCountBitWidth-1:0] words_left_q;
  logic [31:0]                  data_out_q;
  logic                         data_valid_q;
  logic                         busy_q;
  logic                         done_q;
  logic                         cs_q;
  logic                         sclk_q;
  logic                         mosi_q;

  logic        accept_d;
  logic        can_load_d;
  logic        word_end_d;
  logic        last_word_d;
  logic [31:0] rx_swap_d;

  assign accept_d    = data_valid_q & data_ready;
  assign can_load_d  = ~data_valid_q | data_ready;
  assign last_word_d = words_left_q == WordCountBitWidth'(1);
  assign rx_swap_d   = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};

  // A word is complete at the end of its 32nd high phase, or while parked.
  assign word_end_d = stall_q |
                      (state_q == ReadData && phase_q &&
                       bit_cnt_q == CntW'(31));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= Idle;
      phase_q      <= 1'b0;
      stall_q      <= 1'b0;
      bit_cnt_q    <= '0;
      tx_q         <= '0;
      rx_q         <= '0;
      words_left_q <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cs_q         <= 1'b1;
      sclk_q       <= 1'b0;
      mosi_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept_d) data_valid_q <= 1'b0;
      unique case (state_q)
        Idle: begin
          if (start) begin
            if (word_count == '0) begin
              done_q  <= 1'b1;
              state_q <= Finish;
            end else begin
              words_left_q <= word_count;
              tx_q         <= {Cmd, address};
              mosi_q       <= Cmd[7];
              cs_q         <= 1'b0;
              busy_q       <= 1'b1;
              phase_q      <= 1'b0;
              stall_q      <= 1'b0;
              bit_cnt_q    <= '0;
              state_q      <= SendCommand;
            end
          end
        end
        Finish: state_q <= Idle;
        default: begin
          if (word_end_d) begin
            sclk_q  <= 1'b0;
            phase_q <= 1'b0;
            if (can_load_d) begin
              stall_q      <= 1'b0;
              data_out_q   <= rx_swap_d;
              data_valid_q <= 1'b1;
              bit_cnt_q    <= '0;
              words_left_q <= words_left_q - WordCountBitWidth'(1);
              if (last_word_d) begin
                cs_q    <= 1'b1;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= Finish;
              end
            end else begin
              stall_q <= 1'b1;
            end
          end else if (!phase_q) begin
            sclk_q  <= 1'b1;
            phase_q <= 1'b1;
            if (state_q == ReadData) rx_q <= {rx_q[30:0], flash_miso};
          end else begin
            sclk_q    <= 1'b0;
            phase_q   <= 1'b0;
            tx_q      <= tx_q << 1;
            mosi_q    <= tx_q[TxW-2];
            bit_cnt_q <= bit_cnt_q + CntW'(1);
            unique case (state_q)
              SendCommand: begin
                if (bit_cnt_q == CntW'(7)) begin
                  bit_cnt_q <= '0;
                  state_q   <= SendAddress;
                end
              end
              SendAddress: begin
                if (bit_cnt_q == CntW'(AddressBitWidth - 1)) begin
                  bit_cnt_q <= '0;
`ifdef FLASH_READER_FAST_READ_EN
                  state_q   <= Dummy;
`else
                  state_q   <= ReadData;
`endif
                end
              end
              Dummy: begin
                if (bit_cnt_q == CntW'(7)) begin
                  bit_cnt_q <= '0;
                  state_q   <= ReadData;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign flash_clk  = sclk_q;
  assign flash_mosi = mosi_q;
  assign flash_cs   = cs_q;

endmodule

// File: doc/flash_reader.md
FLASH_READER -- requirements
Module: flash_reader

Interface
REQ-001 SHALL have parameter WordCountBitWidth, default 16, meaning the width of word_count.
REQ-002 SHALL have parameter AddressBitWidth, default 24, meaning the width of the flash byte address sent on SPI.
REQ-003 SHALL have port clk  input  1  system clock; the single clock for all logic.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a read.
REQ-006 SHALL have port address  input  AddressBitWidth  byte address of the first flash byte.
REQ-007 SHALL have port word_count  input  WordCountBitWidth  number of 32-bit words to read.
REQ-008 SHALL have port busy  output  1  high while a read is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when a read completes.
REQ-010 SHALL have port data_out  output  32  assembled word.
REQ-011 SHALL have port data_valid  output  1  data_out holds an unaccepted word.
REQ-012 SHALL have port data_ready  input  1  consumer accepts data_out in any cycle where data_valid and data_ready are both high.
REQ-013 SHALL have ports flash_clk (output 1), flash_mosi (output 1), flash_miso (input 1) and flash_cs (output 1, active-low, meaning the SPI mode-0 link to flash).

Function
REQ-014 SHALL use states Idle, SendCommand, SendAddress, Dummy, ReadData and Finish.
REQ-015 SHALL accept start only in Idle; start while busy SHALL be ignored; address and word_count SHALL be latched on acceptance.
REQ-016 SHALL handle word_count 0 this way: no flash_cs assertion, and done pulses on the cycle after start.
REQ-017 SHALL drive flash_cs low on the cycle after start is accepted, and busy SHALL be high from that same cycle.
REQ-018 SHALL make each SPI bit 2 clk cycles: flash_clk low with mosi stable, then flash_clk high; flash_miso is sampled at the edge where flash_clk rises.
REQ-019 SHALL send the command byte 0x03, then the address, both MSB first.
REQ-020 SHALL fill bytes into each word little-endian: the first byte received goes to data_out[7:0], and each byte is received MSB first.
REQ-021 SHALL use a shift register plus a holding register; a completed word moves to data_out and sets data_valid.
REQ-022 SHALL stall when the shift word is complete and data_valid is still high: flash_clk is held low and flash_cs stays low until the consumer accepts.
REQ-023 SHALL allow acceptance and a new word transfer in the same cycle, with no bubble.
REQ-024 SHALL raise flash_cs (high) after the last bit of the final word; it then enters Finish, pulses done for 1 cycle, and drops busy in that cycle.
REQ-025 SHALL allow the final word to remain valid after done until it is accepted.
REQ-026 SHALL produce the first data_valid 128 clk cycles after flash_cs falls, when there is no stall (144 with FLASH_READER_FAST_READ_EN).
REQ-027 SHALL keep flash_clk low whenever flash_cs is high.

Reset
REQ-028 SHALL set on reset: flash_cs=1, flash_clk=0, flash_mosi=0, busy=0, done=0, data_valid=0, data_out=0, state=Idle.
REQ-029 SHALL treat reset mid-transfer the same way: the transfer aborts and all outputs reach their reset values at the next edge; no done is produced.

Configuration
REQ-030 SHALL use macro FLASH_READER_FAST_READ_EN; when defined, the command is 0x0B, followed by the address and then 8 dummy clocks (Dummy state, miso ignored).
REQ-031 SHALL, when FLASH_READER_FAST_READ_EN is undefined, use command 0x03; the Dummy state is never entered.

Verification
REQ-032 SHALL cover: flash bytes 13 00 00 00 37 55 34 12 at address 0; start, address 0, word_count 2, data_ready=1 -> data_out 0x00000013 then 0x12345537, one done pulse.
REQ-033 SHALL cover: a check of the mosi stream in that same read -> 32 bits 0x03_000000 observed on flash_clk rising edges, flash_cs low throughout.
REQ-034 SHALL cover: data_ready=0 for 200 cycles after the first word -> flash_clk is static low, flash_cs stays low, the second word stays 0x12345537, no word is lost.
REQ-035 SHALL cover: word_count 0 -> done pulse 1 cycle after start, flash_cs never low.
REQ-036 SHALL cover: rst asserted during the address phase -> flash_cs=1 and busy=0 next cycle; a new start afterwards reads 0x00000013 correctly.
REQ-037 SHALL cover: with FLASH_READER_FAST_READ_EN defined, same read as REQ-032 -> command 0x0B, 8 dummy clocks, identical data, first valid at cycle 144.
